// File: rtl/alu_seq.sv
// Handshaked sequential ALU: Nand2Tetris-style control word plus a multi-cycle
// shift-and-add multiply and a bit-serial left shift, with z/n/c flags.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [SHW:0] LP_MUL_CNT = (SHW+1)'(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_ax;
    logic [WIDTH-1:0]   r_ay;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [SHW:0]       r_cnt;
    logic               r_no;
    logic               r_is_mul;
    logic [WIDTH-1:0]   r_out;
    logic               r_fz;
    logic               r_fn;
    logic               r_fc;

    logic [WIDTH-1:0]   w_ax_z, w_ax, w_ay_z, w_ay;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_alu_v, w_direct_v, w_direct_out;
    logic               w_direct_c;
    logic               w_mode_mul, w_mode_shl, w_needs_busy;
    logic [SHW:0]       w_n;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_sh_next, w_busy_v, w_busy_out;
    logic               w_busy_c;
    logic [WIDTH-1:0]   w_fin_out;
    logic               w_fin_c;
    logic               w_enter_done;

    assign w_ax_z = ctrl[5] ? '0 : x;
    assign w_ax   = ctrl[4] ? ~w_ax_z : w_ax_z;
    assign w_ay_z = ctrl[3] ? '0 : y;
    assign w_ay   = ctrl[2] ? ~w_ay_z : w_ay_z;
    assign w_sum  = {1'b0, w_ax} + {1'b0, w_ay};

    assign w_mode_mul   = (mode == 2'b01);
    assign w_mode_shl   = (mode == 2'b10);
    assign w_n          = {1'b0, w_ay[SHW-1:0]};
    assign w_needs_busy = w_mode_mul || (w_mode_shl && (w_n != '0));

    // Single-cycle results: ALU modes, and a zero-length shift which passes ax through.
    assign w_alu_v      = ctrl[1] ? w_sum[WIDTH-1:0] : (w_ax & w_ay);
    assign w_direct_v   = w_mode_shl ? w_ax : w_alu_v;
    assign w_direct_out = ctrl[0] ? ~w_direct_v : w_direct_v;
    assign w_direct_c   = !w_mode_shl && ctrl[1] && w_sum[WIDTH];

    assign w_acc_next = r_acc + (r_ay[0] ? r_mcand : '0);
    assign w_sh_next  = {r_ax[WIDTH-2:0], 1'b0};
    assign w_busy_v   = r_is_mul ? w_acc_next[WIDTH-1:0] : w_sh_next;
    assign w_busy_out = r_no ? ~w_busy_v : w_busy_v;
    assign w_busy_c   = r_is_mul ? (|w_acc_next[2*WIDTH-1:WIDTH]) : r_ax[WIDTH-1];

    assign w_fin_out    = (r_state == S_IDLE) ? w_direct_out : w_busy_out;
    assign w_fin_c      = (r_state == S_IDLE) ? w_direct_c : w_busy_c;
    assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = w_needs_busy ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (r_cnt == 1) w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ax     <= '0;
            r_ay     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_no     <= 1'b0;
            r_is_mul <= 1'b0;
            r_out    <= '0;
            r_fz     <= 1'b0;
            r_fn     <= 1'b0;
            r_fc     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_ax     <= w_ax;
                r_ay     <= w_ay;
                r_no     <= ctrl[0];
                r_is_mul <= w_mode_mul;
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_ax};
                r_cnt    <= w_mode_mul ? LP_MUL_CNT : w_n;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_is_mul) begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_ay    <= r_ay >> 1;
                end else begin
                    r_ax <= w_sh_next;
                end
            end
            if (w_enter_done) begin
                r_out <= w_fin_out;
                r_fz  <= (w_fin_out == '0);
                r_fn  <= w_fin_out[WIDTH-1];
                r_fc  <= w_fin_c;
            end
        end
    end

    assign out    = r_out;
    assign flag_z = r_fz;
    assign flag_n = r_fn;
    assign flag_c = r_fc;
endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq: results, flags, latency, backpressure and reset abort.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [5:0]   ctrl = '0;
    logic [1:0]   mode = '0;
    logic         in_ready, out_valid, flag_z, flag_n, flag_c;
    logic [W-1:0] out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctrl;
        logic [1:0]  mode;
        logic [15:0] e_out;
        logic [2:0]  e_flags;   // {z, n, c}
        int          e_lat;
    } vec_t;

    vec_t vecs[14];

    alu_seq #(.WIDTH(W), .SHW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ctrl(ctrl), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one command and wait for out_valid; leaves the result parked in DONE.
    task automatic run_cmd(input vec_t v, input string tag);
        int guard = 0;
        int lat = 1;
        bit busy_ok = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        x = v.x; y = v.y; ctrl = v.ctrl; mode = v.mode; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); ctrl = ~ctrl;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.e_lat));
        chk({tag, " out"}, 32'(out), 32'(v.e_out));
        chk({tag, " flags"}, 32'({flag_z, flag_n, flag_c}), 32'(v.e_flags));
        chk({tag, " in_ready low while busy"}, 32'(busy_ok), 32'd1);
        $display("%s: x=%h y=%h ctrl=%b mode=%b -> out=%h zncc=%b lat=%0d", tag, v.x, v.y,
                 v.ctrl, v.mode, out, {flag_z, flag_n, flag_c}, lat);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " idle after release"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        bit stray;
        vecs[0]  = '{16'd5,    16'd3,    6'b010011, 2'b00, 16'h0002, 3'b000, 1};
        vecs[1]  = '{16'h1234, 16'h5678, 6'b101010, 2'b00, 16'h0000, 3'b100, 1};
        vecs[2]  = '{16'h1234, 16'h5678, 6'b111010, 2'b00, 16'hFFFF, 3'b010, 1};
        vecs[3]  = '{16'hFFFF, 16'h0001, 6'b000010, 2'b00, 16'h0000, 3'b101, 1};
        vecs[4]  = '{16'h0F0F, 16'h00FF, 6'b000000, 2'b00, 16'h000F, 3'b000, 1};
        vecs[5]  = '{16'h1234, 16'h1111, 6'b000010, 2'b11, 16'h2345, 3'b000, 1};
        vecs[6]  = '{16'd300,  16'd300,  6'b000000, 2'b01, 16'h5F90, 3'b001, 17};
        vecs[7]  = '{16'd7,    16'd6,    6'b000010, 2'b01, 16'h002A, 3'b000, 17};
        vecs[8]  = '{16'd2,    16'd3,    6'b000001, 2'b01, 16'hFFF9, 3'b010, 17};
        vecs[9]  = '{16'd0,    16'd5,    6'b000000, 2'b01, 16'h0000, 3'b100, 17};
        vecs[10] = '{16'h8001, 16'd1,    6'b000000, 2'b10, 16'h0002, 3'b001, 2};
        vecs[11] = '{16'h8001, 16'd0,    6'b000000, 2'b10, 16'h8001, 3'b010, 1};
        vecs[12] = '{16'h0003, 16'd15,   6'b000000, 2'b10, 16'h8000, 3'b011, 16};
        vecs[13] = '{16'h4001, 16'h0012, 6'b000010, 2'b10, 16'h0004, 3'b001, 3};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset handshake", 32'({in_ready, out_valid}), 32'b10);
        chk("reset out", 32'(out), 32'h0);
        chk("reset flags", 32'({flag_z, flag_n, flag_c}), 32'h0);

        for (int i = 0; i < 14; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and stray commands must be ignored.
        run_cmd(vecs[0], "bp");
        for (int k = 0; k < 3; k++) begin
            x = 16'hAAAA; y = 16'h5555; ctrl = 6'b000010; mode = 2'b00;
            in_valid = (k != 1);
            @(posedge clk); #1;
            chk($sformatf("bp hold out c%0d", k), 32'(out), 32'h0002);
            chk($sformatf("bp hold flags c%0d", k), 32'({flag_z, flag_n, flag_c}), 32'b000);
            chk($sformatf("bp handshake c%0d", k), 32'({in_ready, out_valid}), 32'b01);
        end
        in_valid = 1'b0;
        release_result("bp");
        @(posedge clk); #1;
        chk("bp no stray accept", 32'(out_valid), 32'd0);
        $display("bp: out held at 0002 for 3 cycles, released");

        // Reset in the middle of a multiply abandons it.
        x = 16'd300; y = 16'd300; ctrl = 6'b000000; mode = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst handshake", 32'({in_ready, out_valid}), 32'b10);
        chk("midrst out", 32'(out), 32'h0);
        chk("midrst flags", 32'({flag_z, flag_n, flag_c}), 32'h0);
        stray = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) stray = 1'b1;
        end
        chk("midrst no result", 32'(stray), 32'd0);
        $display("midrst: multiply abandoned at cycle 8");
        run_cmd(vecs[3], "postrst");
        release_result("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
